// File: rtl/x_stream_feeder.sv
// X operand feeder: buffers host bytes in a small FIFO and sequences one compute job per NUM_X-word frame.
// Optional host_last framing check (frame_err output) is enabled with `define X_FEEDER_LAST_CHK_EN.
module x_stream_feeder #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_X      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    output logic              cs_n,
    output logic              start_in,
    output logic              valid_input,
    output logic [DATA_W-1:0] X_load,
    input  logic              finish,
    output logic              job_done,
    output logic              busy
`ifdef X_FEEDER_LAST_CHK_EN
    ,
    output logic              frame_err
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NUM_X + 1);
    localparam logic [CW-1:0] NUM_C    = CW'(NUM_X);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_X - 1);
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [CW-1:0]     acc_cnt, snd_cnt;
    logic              armed;
    logic              empty, full, push, pop;

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    // armed keeps host_ready low while rst is active and for the first edge after it
    assign host_ready = armed && !full && (acc_cnt < NUM_C);
    assign push       = host_valid && host_ready;

    always_comb begin
        state_nxt = state;
        cs_n      = 1'b1;
        start_in  = 1'b0;
        job_done  = 1'b0;
        busy      = 1'b1;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (!empty) state_nxt = S_START;
            end
            S_START: begin
                cs_n      = 1'b0;
                start_in  = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                cs_n = 1'b0;
                pop  = !empty;
                if (valid_input && (snd_cnt == LAST_IDX)) state_nxt = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                cs_n = 1'b0;
                if (finish) state_nxt = S_DONE;
            end
            S_DONE: begin
                job_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            valid_input <= 1'b0;
            X_load      <= '0;
            acc_cnt     <= '0;
            snd_cnt     <= '0;
            armed       <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            // X_load holds its last value through bubbles
            valid_input <= pop;
            if (pop) X_load <= mem[rd_ptr];
            if (state == S_DONE)  acc_cnt <= '0;
            else if (push)        acc_cnt <= acc_cnt + CW'(1);
            if (state == S_DONE)  snd_cnt <= '0;
            else if (valid_input) snd_cnt <= snd_cnt + CW'(1);
        end
    end

`ifdef X_FEEDER_LAST_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (push) begin
            if (host_last != (acc_cnt == LAST_IDX)) frame_err <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = host_last;
`endif

endmodule

// File: tb/tb_x_stream_feeder.sv
// Self-checking bench for x_stream_feeder: scoreboard of accepted host words vs X_load, plus a simple core model driving finish.
module tb_x_stream_feeder;

    localparam int DATA_W = 8;
    localparam int NUM_X  = 32;

    logic              clk, rst;
    logic              host_valid, host_last, host_ready;
    logic [DATA_W-1:0] host_data, X_load;
    logic              cs_n, start_in, valid_input, finish, job_done, busy;
`ifdef X_FEEDER_LAST_CHK_EN
    logic              frame_err;
`endif

    x_stream_feeder #(.DATA_W(DATA_W), .FIFO_DEPTH(8), .NUM_X(NUM_X)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last), .host_ready(host_ready),
        .cs_n(cs_n), .start_in(start_in), .valid_input(valid_input), .X_load(X_load),
        .finish(finish), .job_done(job_done), .busy(busy)
`ifdef X_FEEDER_LAST_CHK_EN
        , .frame_err(frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [DATA_W-1:0] sb [$];
    int vjob = 0, starts_job = 0, cs_bad = 0, acc_model = 0;
    int jobs_done = 0, jobs_streamed = 0, starts_seen = 0;
    int fin_delay = 5, fin_served = 0, stray_served = 0, cd = -1, scd = -1;
    bit stray_en = 0, abort = 0, sender_busy = 0, ready_pend = 0;
    logic fin_prev = 1'b0;
    int done_before;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge; acceptance is judged at the falling edge.
    task automatic send(input int n, input int base, input int gap, input int bad_last);
        int i = 0, guard = 0, gapcnt = 0;
        sender_busy = 1;
        while (1) begin
            @(posedge clk); #2;
            if (i >= n || abort || guard > 4000) break;
            guard++;
            if (gapcnt > 0) begin
                host_valid = 1'b0;
                gapcnt--;
            end else begin
                host_valid = 1'b1;
                host_data  = DATA_W'(base + i);
                host_last  = (((base + i) % NUM_X) == NUM_X - 1) || (i == bad_last);
                @(negedge clk);
                if (host_ready) begin
                    i++;
                    gapcnt = gap;
                end
            end
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
        if (!abort) check("send_done", i, n);
        sender_busy = 0;
    endtask

    task automatic wait_jobs(input int n);
        int g = 0;
        while (jobs_done < n && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("job_count", jobs_done, n);
    endtask

    // monitor + scoreboard
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            vjob = 0; starts_job = 0; cs_bad = 0; acc_model = 0; ready_pend = 0;
        end else begin
            if (ready_pend) begin
                check("ready_low_full", int'(host_ready), 0);
                ready_pend = 0;
            end
            if (host_valid && host_ready) begin
                sb.push_back(host_data);
                acc_model++;
                if (acc_model == NUM_X) ready_pend = 1;
            end
            if (valid_input) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else                check("x_load", int'(X_load), int'(sb.pop_front()));
                vjob++;
                if (vjob == NUM_X) jobs_streamed++;
            end
            if (start_in) begin
                starts_job++;
                starts_seen++;
            end
            if (job_done) begin
                check("starts_per_job", starts_job, 1);
                check("vin_per_job", vjob, NUM_X);
                check("cs_busy_in_job", cs_bad, 0);
                check("done_after_fin", int'(fin_prev), 1);
                jobs_done++;
                vjob = 0; starts_job = 0; cs_bad = 0; acc_model = 0;
            end else if (starts_job > 0 && (cs_n || !busy)) begin
                cs_bad++;
            end
        end
        fin_prev = finish;
    end

    // core model: finish fin_delay cycles after the last word, optional stray pulse during STREAM
    initial begin
        finish = 1'b0;
        forever begin
            @(posedge clk); #2;
            finish = 1'b0;
            if (!stray_en) stray_served = starts_seen;
            else if (starts_seen > stray_served) begin
                if (scd < 0) scd = 3;
                else if (scd == 0) begin finish = 1'b1; stray_served++; scd = -1; end
                else scd--;
            end
            if (jobs_streamed > fin_served) begin
                if (cd < 0) cd = fin_delay - 1;
                else if (cd == 0) begin finish = 1'b1; fin_served++; cd = -1; end
                else cd--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1'b1; host_valid = 1'b0; host_data = '0; host_last = 1'b0;
        repeat (3) @(posedge clk); #2;
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_host_ready", int'(host_ready), 0);
        check("rst_x_load", int'(X_load), 0);
        check("rst_job_done", int'(job_done), 0);
        check("rst_valid", int'(valid_input), 0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("idle_cs_n", int'(cs_n), 1);
        check("idle_start", int'(start_in), 0);
        check("idle_valid", int'(valid_input), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_host_ready", int'(host_ready), 1);

        fin_delay = 5;
        send(32, 0, 0, -1);
        wait_jobs(1);

        fin_delay = 50;
        send(64, 32, 0, -1);
        wait_jobs(3);

        fin_delay = 5;
        stray_en  = 1;
        send(32, 96, 2, -1);
        wait_jobs(4);
        stray_en = 0;

        done_before = jobs_done;
        fork
            send(32, 128, 0, -1);
        join_none
        g = 0;
        while (vjob < 10 && g < 500) begin @(negedge clk); g++; end
        check("reach_10_words", int'(vjob >= 10), 1);
        abort = 1;
        g = 0;
        while (sender_busy && g < 100) begin @(negedge clk); g++; end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_cs_n", int'(cs_n), 1);
        check("mid_rst_start", int'(start_in), 0);
        check("mid_rst_valid", int'(valid_input), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_job_done", int'(job_done), 0);
        check("mid_rst_x_load", int'(X_load), 0);
        check("mid_rst_host_ready", int'(host_ready), 0);
        repeat (2) @(posedge clk); #2;
        rst = 1'b0;
        abort = 0;
        send(32, 160, 0, -1);
        wait_jobs(done_before + 1);
        repeat (10) @(negedge clk);
        check("jobs_after_reset", jobs_done, done_before + 1);

`ifdef X_FEEDER_LAST_CHK_EN
        check("frame_err_clean", int'(frame_err), 0);
        send(32, 192, 0, 20);
        wait_jobs(done_before + 2);
        check("frame_err_set", int'(frame_err), 1);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
